// File: rtl/vigna_fetch_align.sv
// Instruction fetch and realignment: fetches aligned 32-bit words and presents one
// 16-bit compressed or 32-bit instruction at a time, including word-straddling ones.
module vigna_fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          C_EXT    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        i_valid,
  input  logic        i_ready,
  output logic [31:0] i_addr,
  input  logic [31:0] i_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_c,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HLEN = 16;
  localparam logic [XLEN-1:0] PC_MASK   = C_EXT ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] RESET_PCM = RESET_PC & PC_MASK;
  localparam logic [XLEN-1:0] RESET_ADR = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic {S_GAP, S_REQ} state_t;

  state_t            state_q, state_d;
  logic              ivalid_q, ivalid_d;
  logic [XLEN-1:0]   iaddr_q, iaddr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [HLEN-1:0]   hbuf_q, hbuf_d;
  logic              hbuf_valid_q, hbuf_valid_d;
  logic              discard_q, discard_d;
  logic              slot_valid_q, slot_valid_d;
  logic [XLEN-1:0]   slot_data_q, slot_data_d;
  logic [XLEN-1:0]   slot_pc_q, slot_pc_d;
  logic              slot_c_q, slot_c_d;

  logic              slot_free;
  logic              hbuf_ahead;
  logic              hbuf_emit;
  logic [XLEN-1:0]   fetch_addr;
  logic [XLEN-1:0]   pc_plus2;
  logic [XLEN-1:0]   pc_plus4;

  // Upper half buffered for the current halfword PC: emit it or fetch the next word.
  assign slot_free  = !slot_valid_q || inst_ready;
  assign hbuf_ahead = C_EXT && pc_q[1] && hbuf_valid_q;
  assign hbuf_emit  = hbuf_ahead && (hbuf_q[1:0] != 2'b11);
  assign fetch_addr = hbuf_ahead ? {pc_q[31:2] + 30'd1, 2'b00} : {pc_q[31:2], 2'b00};
  assign pc_plus2   = pc_q + 32'd2;
  assign pc_plus4   = pc_q + 32'd4;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_GAP;
      ivalid_q     <= 1'b0;
      iaddr_q      <= RESET_ADR;
      pc_q         <= RESET_PCM;
      hbuf_q       <= '0;
      hbuf_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_pc_q    <= '0;
      slot_c_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ivalid_q     <= ivalid_d;
      iaddr_q      <= iaddr_d;
      pc_q         <= pc_d;
      hbuf_q       <= hbuf_d;
      hbuf_valid_q <= hbuf_valid_d;
      discard_q    <= discard_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_pc_q    <= slot_pc_d;
      slot_c_q     <= slot_c_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ivalid_d     = ivalid_q;
    iaddr_d      = iaddr_q;
    pc_d         = pc_q;
    hbuf_d       = hbuf_q;
    hbuf_valid_d = hbuf_valid_q;
    discard_d    = discard_q;
    slot_valid_d = slot_valid_q && !inst_ready;
    slot_data_d  = slot_data_q;
    slot_pc_d    = slot_pc_q;
    slot_c_d     = slot_c_q;

    case (state_q)
      S_GAP: begin
        if (!flush && slot_free) begin
          if (hbuf_emit) begin
            slot_valid_d = 1'b1;
            slot_data_d  = {16'h0000, hbuf_q};
            slot_pc_d    = pc_q;
            slot_c_d     = 1'b1;
            pc_d         = pc_plus2;
            hbuf_valid_d = 1'b0;
          end else begin
            state_d  = S_REQ;
            ivalid_d = 1'b1;
            iaddr_d  = fetch_addr;
          end
        end
      end
      S_REQ: begin
        if (i_ready) begin
          state_d   = S_GAP;
          ivalid_d  = 1'b0;
          discard_d = 1'b0;
          // A flush in this cycle or an earlier one makes the response stale.
          if (!flush && !discard_q) begin
            if (!C_EXT) begin
              slot_valid_d = 1'b1;
              slot_data_d  = i_rdata;
              slot_pc_d    = pc_q;
              slot_c_d     = 1'b0;
              pc_d         = pc_plus4;
              hbuf_valid_d = 1'b0;
            end else if (!pc_q[1]) begin
              slot_valid_d = 1'b1;
              slot_pc_d    = pc_q;
              if (i_rdata[1:0] != 2'b11) begin
                slot_data_d  = {16'h0000, i_rdata[15:0]};
                slot_c_d     = 1'b1;
                hbuf_d       = i_rdata[31:16];
                hbuf_valid_d = 1'b1;
                pc_d         = pc_plus2;
              end else begin
                slot_data_d  = i_rdata;
                slot_c_d     = 1'b0;
                hbuf_valid_d = 1'b0;
                pc_d         = pc_plus4;
              end
            end else if (hbuf_valid_q) begin
              slot_valid_d = 1'b1;
              slot_data_d  = {i_rdata[15:0], hbuf_q};
              slot_pc_d    = pc_q;
              slot_c_d     = 1'b0;
              hbuf_d       = i_rdata[31:16];
              hbuf_valid_d = 1'b1;
              pc_d         = pc_plus4;
            end else begin
              // Halfword redirect target: only the upper half is wanted.
              hbuf_d       = i_rdata[31:16];
              hbuf_valid_d = 1'b1;
            end
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_GAP;
    endcase

    if (flush) begin
      slot_valid_d = 1'b0;
      hbuf_valid_d = 1'b0;
      pc_d         = flush_pc & PC_MASK;
    end
  end

  assign i_valid    = ivalid_q;
  assign i_addr     = iaddr_q;
  assign inst_valid = slot_valid_q;
  assign inst_data  = slot_data_q;
  assign inst_pc    = slot_pc_q;
  assign inst_is_c  = slot_c_q;

endmodule

// File: tb/tb_vigna_fetch_align.sv
// Directed bench for vigna_fetch_align: RVC and non-RVC instances against a small word memory.
module tb_vigna_fetch_align;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        i_valid, i_ready, inst_valid, inst_ready, inst_is_c, flush;
  logic [31:0] i_addr, i_rdata, inst_data, inst_pc, flush_pc;
  logic        n_i_valid, n_i_ready, n_inst_valid, n_inst_ready, n_inst_is_c, n_flush;
  logic [31:0] n_i_addr, n_i_rdata, n_inst_data, n_inst_pc, n_flush_pc;

  logic [31:0] mem [0:127];
  logic        mem_stall;
  int          errors = 0;
  int          checks = 0;
  int          hs_cnt = 0;
  int          hs_mark;
  logic [31:0] hs_addr = '0;
  logic        hold_ok;

  vigna_fetch_align #(.RESET_PC(32'h0000_0000), .C_EXT(1'b1)) u_dut (
    .clk(clk), .resetn(resetn), .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rdata(i_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .inst_is_c(inst_is_c), .flush(flush), .flush_pc(flush_pc));

  vigna_fetch_align #(.RESET_PC(32'h0000_0000), .C_EXT(1'b0)) u_dut_n (
    .clk(clk), .resetn(resetn), .i_valid(n_i_valid), .i_ready(n_i_ready), .i_addr(n_i_addr),
    .i_rdata(n_i_rdata), .inst_valid(n_inst_valid), .inst_ready(n_inst_ready),
    .inst_data(n_inst_data), .inst_pc(n_inst_pc), .inst_is_c(n_inst_is_c), .flush(n_flush),
    .flush_pc(n_flush_pc));

  // Zero-latency memory responders; the RVC one can be stalled.
  initial begin
    i_ready = 1'b0;
    i_rdata = '0;
    forever begin
      @(negedge clk);
      if (i_ready) i_ready = 1'b0;
      else if (i_valid && !mem_stall) begin
        i_ready = 1'b1;
        i_rdata = mem[i_addr[8:2]];
      end
    end
  end

  initial begin
    n_i_ready = 1'b0;
    n_i_rdata = '0;
    forever begin
      @(negedge clk);
      if (n_i_ready) n_i_ready = 1'b0;
      else if (n_i_valid) begin
        n_i_ready = 1'b1;
        n_i_rdata = mem[n_i_addr[8:2]];
      end
    end
  end

  initial forever begin
    @(posedge clk);
    if (i_valid && i_ready) begin
      hs_cnt++;
      hs_addr = i_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_inst(input string tag);
    int n = 0;
    while (!inst_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " arrives"}, 32'(inst_valid), 32'd1);
  endtask

  task automatic wait_n_inst(input string tag);
    int n = 0;
    while (!n_inst_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " arrives"}, 32'(n_inst_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!i_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " request"}, 32'(i_valid), 32'd1);
  endtask

  task automatic pulse_accept();
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_ready = 1'b0; flush = 1'b0; flush_pc = '0;
    n_inst_ready = 1'b0; n_flush = 1'b0; n_flush_pc = '0;
    mem_stall = 1'b0;
    for (int k = 0; k < 128; k++) mem[k] = 32'h0000_0013;
    mem[0]   = 32'h0081_50a9;
    mem[8]   = 32'h2023_4505;
    mem[9]   = 32'h0013_0010;
    mem[10]  = 32'hffff_ffff;
    mem[64]  = 32'h0081_1234;
    mem[127] = 32'h0010_0073;

    #1;
    chk("rst i_valid", 32'(i_valid), 32'd0);
    chk("rst i_addr", i_addr, 32'h0);
    chk("rst inst_valid", 32'(inst_valid), 32'd0);
    chk("rst inst_data", inst_data, 32'h0);
    chk("rst inst_pc", inst_pc, 32'h0);
    chk("rst inst_is_c", 32'(inst_is_c), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Two compressed instructions from one word
    wait_inst("c0");
    chk("c0 data", inst_data, 32'h0000_50a9);
    chk("c0 pc", inst_pc, 32'h0);
    chk("c0 is_c", 32'(inst_is_c), 32'd1);
    chk("c0 fetches", 32'(hs_cnt), 32'd1);
    chk("c0 addr", hs_addr, 32'h0);

    hold_ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (inst_valid !== 1'b1 || inst_data !== 32'h0000_50a9 || inst_pc !== 32'h0) hold_ok = 1'b0;
    end
    chk("hold stable", 32'(hold_ok), 32'd1);
    chk("hold no fetch", 32'(hs_cnt), 32'd1);
    chk("hold i_valid", 32'(i_valid), 32'd0);

    inst_ready = 1'b1;
    @(negedge clk);
    chk("c1 next cycle", 32'(inst_valid), 32'd1);
    chk("c1 data", inst_data, 32'h0000_0081);
    chk("c1 pc", inst_pc, 32'h2);
    chk("c1 is_c", 32'(inst_is_c), 32'd1);
    chk("c1 no refetch", 32'(hs_cnt), 32'd1);
    @(negedge clk);
    inst_ready = 1'b0;
    chk("w1 i_valid", 32'(i_valid), 32'd1);
    chk("w1 i_addr", i_addr, 32'h4);
    wait_inst("w1");
    chk("w1 data", inst_data, 32'h0000_0013);
    chk("w1 pc", inst_pc, 32'h4);
    chk("w1 is_c", 32'(inst_is_c), 32'd0);

    // Flush over an unaccepted slot, then a straddling instruction
    flush = 1'b1; flush_pc = 32'h0000_0020;
    @(negedge clk);
    flush = 1'b0;
    chk("flush clears slot", 32'(inst_valid), 32'd0);
    hs_mark = hs_cnt;
    wait_inst("s0");
    chk("s0 data", inst_data, 32'h0000_4505);
    chk("s0 pc", inst_pc, 32'h20);
    chk("s0 is_c", 32'(inst_is_c), 32'd1);
    pulse_accept();
    wait_inst("s1");
    chk("s1 data", inst_data, 32'h0010_2023);
    chk("s1 pc", inst_pc, 32'h22);
    chk("s1 is_c", 32'(inst_is_c), 32'd0);
    chk("s1 fetches", 32'(hs_cnt - hs_mark), 32'd2);
    chk("s1 addr", hs_addr, 32'h24);

    // Flush while a request is pending: response discarded, refetch at 0x100
    mem_stall = 1'b1;
    pulse_accept();
    wait_req("hb");
    chk("hb i_addr", i_addr, 32'h28);
    flush = 1'b1; flush_pc = 32'h0000_0102;
    @(negedge clk);
    flush = 1'b0;
    hs_mark = hs_cnt;
    repeat (3) @(negedge clk);
    chk("pend i_valid held", 32'(i_valid), 32'd1);
    chk("pend i_addr held", i_addr, 32'h28);
    mem_stall = 1'b0;
    wait_inst("f0");
    chk("f0 data", inst_data, 32'h0000_0081);
    chk("f0 pc", inst_pc, 32'h102);
    chk("f0 is_c", 32'(inst_is_c), 32'd1);
    chk("f0 fetches", 32'(hs_cnt - hs_mark), 32'd2);
    chk("f0 refetch addr", hs_addr, 32'h100);

    // Non-RVC instance: whole words, halfword bits of flush target dropped, PC wrap
    chk("n0 valid", 32'(n_inst_valid), 32'd1);
    chk("n0 data", n_inst_data, 32'h0081_50a9);
    chk("n0 pc", n_inst_pc, 32'h0);
    chk("n0 is_c", 32'(n_inst_is_c), 32'd0);
    n_flush = 1'b1; n_flush_pc = 32'h0000_0006;
    @(negedge clk);
    n_flush = 1'b0;
    wait_n_inst("n1");
    chk("n1 data", n_inst_data, 32'h0000_0013);
    chk("n1 pc", n_inst_pc, 32'h4);
    chk("n1 i_addr", n_i_addr, 32'h4);
    n_flush = 1'b1; n_flush_pc = 32'hFFFF_FFFE;
    @(negedge clk);
    n_flush = 1'b0;
    wait_n_inst("n2");
    chk("n2 data", n_inst_data, 32'h0010_0073);
    chk("n2 pc", n_inst_pc, 32'hFFFF_FFFC);
    n_inst_ready = 1'b1;
    @(negedge clk);
    n_inst_ready = 1'b0;
    chk("n wrap i_addr", n_i_addr, 32'h0);

    // Asynchronous reset during a stalled request
    mem_stall = 1'b1;
    pulse_accept();
    wait_req("r0");
    chk("r0 i_addr", i_addr, 32'h104);
    #2 resetn = 1'b0;
    #1;
    chk("async i_valid", 32'(i_valid), 32'd0);
    chk("async inst_valid", 32'(inst_valid), 32'd0);
    chk("async i_addr", i_addr, 32'h0);
    chk("async n_inst_valid", 32'(n_inst_valid), 32'd0);
    mem_stall = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    wait_req("post rst");
    chk("post rst i_addr", i_addr, 32'h0);
    wait_inst("post rst inst");
    chk("post rst data", inst_data, 32'h0000_50a9);
    chk("post rst pc", inst_pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
